// File: rtl/corefifo_rd_ptr_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic: Gray/binary
// conversion helpers and the read-side flag bundle.
package corefifo_rd_ptr_ctrl_pkg;

  localparam int ADDRWIDTH_DEF = 3;
  localparam int PTR_W         = ADDRWIDTH_DEF + 1;

  typedef struct packed {
    logic fifo_empty;
    logic aempty;
    logic underflow;
  } rd_flags_t;

  // Width-agnostic: callers zero-extend to 32 bits and cast the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary decode of a synchronized FIFO pointer;
// shared by the read and write controllers.
module corefifo_gray2bin
  import corefifo_rd_ptr_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointer, flags, level.
// Define CORE_RD_FWFT_EN for the first-word-fall-through output stage.
module corefifo_rd_ptr_ctrl
  import corefifo_rd_ptr_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int AE_THRESH = 1,
  parameter int DWIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 re,
  input  logic [ADDRWIDTH:0]   wptr_gray_sync,
  input  logic [DWIDTH-1:0]    ram_rdata,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic                 ram_re,
  output logic [DWIDTH-1:0]    rdata,
  output logic                 rvalid,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rd_cnt,
  output logic                 underflow
);

  localparam int            PW     = ADDRWIDTH + 1;
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  logic [PW-1:0] wbin_s;
  logic [PW-1:0] fifo_lvl_s;
  logic [PW-1:0] extra_s;
  logic [PW-1:0] rptr_bin_q, rptr_bin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] rd_cnt_q, rd_cnt_d;
  rd_flags_t     flags_q, flags_d;
  logic          fetch_s;
  logic          rvalid_q, rvalid_d;

`ifdef CORE_RD_FWFT_EN
  logic              s1_q, s1_d;
  logic              move_s, pop_s;
  logic              empty_q;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
`endif

  corefifo_gray2bin #(.W(PW)) u_wptr_dec (
    .gray_i (wptr_gray_sync),
    .bin_o  (wbin_s)
  );

  always_comb begin
    flags_d = '0;
`ifdef CORE_RD_FWFT_EN
    // s1 marks a word sitting on ram_rdata; the RAM holds it until the next ram_re.
    pop_s    = re & rvalid_q;
    move_s   = s1_q & (~rvalid_q | re);
    fetch_s  = ~flags_q.fifo_empty & (~(rvalid_q & s1_q) | re) & ~srst;
    s1_d     = fetch_s | (s1_q & ~move_s);
    rvalid_d = move_s | (rvalid_q & ~pop_s);
    rdata_d  = move_s ? ram_rdata : rdata_q;
    flags_d.underflow = re & ~rvalid_q;
    extra_s  = PW'(s1_d) + PW'(rvalid_d);
`else
    fetch_s  = re & ~flags_q.fifo_empty & ~srst;
    rvalid_d = fetch_s;
    flags_d.underflow = re & flags_q.fifo_empty;
    extra_s  = '0;
`endif
    rptr_bin_d  = rptr_bin_q + PW'(fetch_s);
    rptr_gray_d = PW'(bin2gray(32'(rptr_bin_d)));
    // Level against the post-read pointer, so a read this edge cannot over-read next edge.
    fifo_lvl_s  = wbin_s - rptr_bin_d;
    rd_cnt_d    = fifo_lvl_s + extra_s;
    flags_d.fifo_empty = (fifo_lvl_s == '0);
    flags_d.aempty     = (rd_cnt_d <= AE_LIM);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      rd_cnt_q    <= '0;
      flags_q     <= '{fifo_empty: 1'b1, aempty: 1'b1, underflow: 1'b0};
      rvalid_q    <= 1'b0;
`ifdef CORE_RD_FWFT_EN
      s1_q        <= 1'b0;
      empty_q     <= 1'b1;
      rdata_q     <= '0;
`endif
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      rd_cnt_q    <= rd_cnt_d;
      flags_q     <= flags_d;
      rvalid_q    <= rvalid_d;
`ifdef CORE_RD_FWFT_EN
      s1_q        <= s1_d;
      empty_q     <= ~rvalid_d;
      rdata_q     <= rdata_d;
`endif
    end
  end

  assign ram_re    = fetch_s;
  assign raddr     = rptr_bin_q[ADDRWIDTH-1:0];
  assign rptr_gray = rptr_gray_q;
  assign rd_cnt    = rd_cnt_q;
  assign aempty    = flags_q.aempty;
  assign underflow = flags_q.underflow;
  assign rvalid    = rvalid_q;
`ifdef CORE_RD_FWFT_EN
  assign empty     = empty_q;
  assign rdata     = rdata_q;
`else
  assign empty     = flags_q.fifo_empty;
  assign rdata     = ram_rdata;
`endif

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Self-checking bench for corefifo_rd_ptr_ctrl (ADDRWIDTH=3, AE_THRESH=1):
// directed scenarios plus random traffic against a word-count reference model.
module tb_corefifo_rd_ptr_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic          re;
  logic [AW:0]   wptr_gray_sync;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          ram_re;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          empty;
  logic          aempty;
  logic [AW:0]   rd_cnt;
  logic          underflow;

  always #5 clk = ~clk;

  corefifo_rd_ptr_ctrl #(.ADDRWIDTH(AW), .AE_THRESH(1), .DWIDTH(DW)) dut (
    .clk            (clk),
    .srst           (srst),
    .re             (re),
    .wptr_gray_sync (wptr_gray_sync),
    .ram_rdata      (ram_rdata),
    .rptr_gray      (rptr_gray),
    .raddr          (raddr),
    .ram_re         (ram_re),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .empty          (empty),
    .aempty         (aempty),
    .rd_cnt         (rd_cnt),
    .underflow      (underflow)
  );

  // RAM model: registered read port that holds its output when not enabled.
  logic [DW-1:0] mem [0:7];
  initial ram_rdata = '0;
  always @(posedge clk) if (ram_re) ram_rdata <= mem[raddr];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: total words written / read as plain integers.
  int         wr = 0;
  int         m_rd = 0;
  bit         m_empty = 1'b1, m_aempty = 1'b1, m_uf = 1'b0, m_rvalid = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic push();
    mem[wr % 8] = 8'($urandom);
    wr++;
  endtask

  // One cycle: drive at posedge+1, check combinational outputs at negedge,
  // advance the model at the edge and check registered outputs at posedge+1.
  task automatic cyc(input bit s, input bit r);
    bit acc;
    srst = s;
    re = r;
    wptr_gray_sync = gray(wr);
    #4;
    chk("ram_re", ram_re, r && !m_empty && !s);
    chk("raddr", raddr, m_rd % 8);
    @(posedge clk);
    if (s) begin
      m_rd = 0; m_cnt = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0; m_rvalid = 1'b0;
    end else begin
      acc = r && !m_empty;
      m_uf = r && m_empty;
      if (acc) begin
        m_data = mem[m_rd % 8];
        m_rd++;
      end
      m_cnt = wr - m_rd;
      m_empty = (m_cnt == 0);
      m_aempty = (m_cnt <= 1);
      m_rvalid = acc;
    end
    #1;
    chk("rptr_gray", rptr_gray, gray(m_rd));
    chk("rd_cnt", rd_cnt, m_cnt);
    chk("empty", empty, m_empty);
    chk("aempty", aempty, m_aempty);
    chk("underflow", underflow, m_uf);
    chk("rvalid", rvalid, m_rvalid);
    if (m_rvalid) chk("rdata", rdata, m_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    srst = 1'b1;
    re = 1'b0;
    wptr_gray_sync = '0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    @(posedge clk);
    #1;
`ifdef CORE_RD_FWFT_EN
    begin
      logic [7:0] words [0:2];
      srst = 1'b0;
      @(negedge clk);
      chk("f_rst_empty", empty, 1);
      chk("f_rst_rvalid", rvalid, 0);
      chk("f_rst_data", rdata, 0);
      for (int k = 0; k < 3; k++) begin
        push();
        words[k] = mem[k];
      end
      wptr_gray_sync = gray(wr);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rvalid === 1'b1) break;
      end
      chk("f_first_valid", rvalid, 1);
      chk("f_cnt3", rd_cnt, 3);
      for (int k = 0; k < 3; k++) begin
        chk("f_order", rdata, words[k]);
        chk("f_valid", rvalid, 1);
        chk("f_nempty", empty, 0);
        re = 1'b1;
        @(negedge clk);
      end
      chk("f_drained_valid", rvalid, 0);
      chk("f_drained_empty", empty, 1);
      chk("f_drained_cnt", rd_cnt, 0);
      @(negedge clk);
      chk("f_uf", underflow, 1);
      re = 1'b0;
      @(negedge clk);
      chk("f_uf_clear", underflow, 0);
    end
`else
    // Reset with wptr at zero
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("s1_empty", empty, 1);
    chk("s1_gray", rptr_gray, 4'b0000);

    // Single word
    push();
    cyc(1'b0, 1'b0);
    chk("s2_cnt", rd_cnt, 1);
    chk("s2_aempty", aempty, 1);
    cyc(1'b0, 1'b1);
    chk("s2_gray", rptr_gray, 4'b0001);
    chk("s2_empty", empty, 1);

    // Full, then sixteen continuous reads across the pointer wrap
    wr = 0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) push();
    cyc(1'b0, 1'b0);
    chk("s3_full_cnt", rd_cnt, 8);
    chk("s3_full_aempty", aempty, 0);
    for (int k = 0; k < 16; k++) begin
      prev = rptr_gray;
      if (wr < 16 && (wr - m_rd) < 8) push();
      cyc(1'b0, 1'b1);
      chk("s3_onebit", $countones(prev ^ rptr_gray), 1);
    end
    chk("s3_gray_end", rptr_gray, 4'b0000);
    chk("s3_empty_end", empty, 1);

    // Underflow on read while empty
    cyc(1'b0, 1'b1);
    chk("s4_uf", underflow, 1);
    chk("s4_gray", rptr_gray, 4'b0000);
    cyc(1'b0, 1'b0);
    chk("s4_uf_pulse", underflow, 0);

    // Reset in the middle of a read burst
    wr = 0;
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) push();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("s5_cnt", rd_cnt, 5);
    cyc(1'b1, 1'b1);
    chk("s5_gray", rptr_gray, 4'b0000);
    chk("s5_rvalid", rvalid, 0);
    cyc(1'b0, 1'b0);
    chk("s5_relevel", rd_cnt, 7);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      bit s;
      s = ($urandom_range(0, 99) == 0);
      if (s) wr = 0;
      else if ((wr - m_rd) < 8 && $urandom_range(0, 99) < 50) push();
      cyc(s, $urandom_range(0, 99) < 60);
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
